// File: rtl/mtm_alu_resp_receiver_pkg.sv
// Shared constants and types for the ALU response receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a; the serial line cannot be stalled.
package mtm_alu_resp_receiver_pkg;

  // Packet framing: start bit, type bit, 8 payload bits, stop bit
  localparam int PKT_LEN         = 11;
  localparam int PKT_SHIFT_BITS  = PKT_LEN - 1;
  localparam int FRAME_DATA_PKTS = 4;

  // CRC x^3 + x + 1 (top term implicit), non-reflected
  localparam logic [2:0] CRC_POLY    = 3'b011;
  localparam logic [2:0] CRC_INIT    = 3'b000;
  localparam int         CRC_MSG_LEN = 37;

  typedef enum logic {
    PKT_DATA = 1'b0,
    PKT_CTRL = 1'b1
  } pkt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  // One serial CRC step: shift in one message bit, MSB first
  function automatic logic [2:0] crc3_step(input logic [2:0] crc, input logic bit_in);
    logic [2:0] shifted;
    shifted = {crc[1:0], 1'b0};
    return (crc[2] ^ bit_in) ? (shifted ^ CRC_POLY) : shifted;
  endfunction

endpackage

// File: rtl/mtm_alu_resp_receiver_crc3.sv
// 3-bit CRC over {result, 1'b0, flags}, MSB first, for result-frame checking.
// Latency: purely combinational.
// Backpressure: none.
module mtm_alu_crc3
  import mtm_alu_resp_receiver_pkg::*;
(
  input  logic [31:0] data,
  input  logic [3:0]  flags,
  output logic [2:0]  crc
);

  logic [CRC_MSG_LEN-1:0] msg;
  logic [2:0]             acc;

  // Walk the 37-bit message from its MSB down through the serial divider
  always_comb begin
    msg = {data, 1'b0, flags};
    acc = CRC_INIT;
    for (int i = CRC_MSG_LEN - 1; i >= 0; i--) begin
      acc = crc3_step(acc, msg[i]);
    end
    crc = acc;
  end

endmodule

// File: rtl/mtm_alu_resp_receiver.sv
// Decodes serial ALU response frames (4 data + 1 control packet, or 1 error control packet).
// Latency: valid/frame_error pulse in the cycle after the stop bit; timeout on 65th idle line cycle.
// Backpressure: none, the line is free-running; optional CRC/parity check via MTM_ALU_RX_CRC_CHECK_EN.
module mtm_alu_resp_receiver
  import mtm_alu_resp_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        valid,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic [5:0]  err_flags,
  output logic        is_error,
  output logic        crc_ok,
  output logic        frame_error
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q;
  state_e            state_n;
  logic [3:0]        bit_cnt_q;
  logic [9:0]        shreg_q;
  logic [2:0]        pkt_cnt_q;
  logic [31:0]       data_buf_q;
  logic [IDLE_W-1:0] idle_cnt_q;

  logic [31:0]       result_q;
  logic [3:0]        flags_q;
  logic [5:0]        err_flags_q;
  logic              is_error_q;

  // Packet fields as captured after the 10 post-start bits
  pkt_type_e         pkt_type;
  logic [7:0]        payload;
  logic              pkt_stop;

  // Per-cycle decisions from the evaluation logic
  logic              store_byte;
  logic              upd_res;
  logic              upd_err;
  logic              pkt_bad;
  logic              idle_open;
  logic              timeout;

  assign pkt_type = pkt_type_e'(shreg_q[9]);
  assign payload  = shreg_q[8:1];
  assign pkt_stop = shreg_q[0];

  // Line is idle while a frame is open; the evaluation cycle already counts as
  // the first idle cycle, so the timeout fires on the TIMEOUT_CYCLES-th IDLE cycle
  assign idle_open = (state_q == ST_IDLE) && sin && (pkt_cnt_q != 3'd0);

  // State register, reset wins over any packet in flight
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  // Next state: a start bit may already be on the line during the evaluation cycle
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (!sin) state_n = ST_SHIFT;
      ST_SHIFT: if (bit_cnt_q == 4'(PKT_SHIFT_BITS - 1)) state_n = ST_CHECK;
      ST_CHECK: state_n = sin ? ST_IDLE : ST_SHIFT;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Evaluate the captured packet against the frame sequence rules, plus the idle timeout
  always_comb begin
    store_byte = 1'b0;
    upd_res    = 1'b0;
    upd_err    = 1'b0;
    pkt_bad    = 1'b0;
    timeout    = 1'b0;
    if (!rst) begin
      if (state_q == ST_CHECK) begin
        if (!pkt_stop) begin
          pkt_bad = 1'b1;
        end else if (pkt_type == PKT_DATA) begin
          if (pkt_cnt_q < 3'(FRAME_DATA_PKTS)) store_byte = 1'b1;
          else                                 pkt_bad    = 1'b1;
        end else if (!payload[7]) begin
          if (pkt_cnt_q == 3'(FRAME_DATA_PKTS)) upd_res = 1'b1;
          else                                  pkt_bad = 1'b1;
        end else begin
          if (pkt_cnt_q == 3'd0) upd_err = 1'b1;
          else                   pkt_bad = 1'b1;
        end
      end
      if (idle_open && (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1))) timeout = 1'b1;
    end
    valid       = upd_res | upd_err;
    frame_error = pkt_bad | timeout;
  end

  // Bit capture: shift the line in while in SHIFT, count the 10 post-start bits
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= 4'd0;
      shreg_q   <= 10'd0;
    end else if (state_q == ST_SHIFT) begin
      bit_cnt_q <= bit_cnt_q + 4'd1;
      shreg_q   <= {shreg_q[8:0], sin};
    end else begin
      bit_cnt_q <= 4'd0;
    end
  end

  // Frame progress: count data packets, drop the partial frame on any error or completion
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= 3'd0;
      data_buf_q <= 32'd0;
    end else begin
      if (frame_error || upd_res) pkt_cnt_q <= 3'd0;
      else if (store_byte)        pkt_cnt_q <= pkt_cnt_q + 3'd1;
      if (store_byte) data_buf_q <= {data_buf_q[23:0], payload};
    end
  end

  // Idle run length while a frame is open
  always_ff @(posedge clk) begin
    if (rst || !idle_open || timeout) idle_cnt_q <= '0;
    else                              idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
  end

  // New fields show up with the valid pulse, otherwise the last decoded frame is held
  always_comb begin
    result    = upd_res ? data_buf_q   : result_q;
    flags     = upd_res ? payload[6:3] : flags_q;
    err_flags = upd_err ? payload[6:1] : err_flags_q;
    is_error  = upd_res ? 1'b0 : (upd_err ? 1'b1 : is_error_q);
  end

  // Held copies of the decoded fields
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= 32'd0;
      flags_q     <= 4'd0;
      err_flags_q <= 6'd0;
      is_error_q  <= 1'b0;
    end else begin
      result_q    <= result;
      flags_q     <= flags;
      err_flags_q <= err_flags;
      is_error_q  <= is_error;
    end
  end

`ifdef MTM_ALU_RX_CRC_CHECK_EN
  logic [2:0] crc_calc;
  logic       crc_ok_q;

  mtm_alu_crc3 u_crc3 (
    .data  (data_buf_q),
    .flags (payload[6:3]),
    .crc   (crc_calc)
  );

  // Result frames compare the CRC field, error frames need even parity over the payload
  always_comb begin
    if (upd_res)      crc_ok = (crc_calc == payload[2:0]);
    else if (upd_err) crc_ok = ~^payload;
    else              crc_ok = crc_ok_q;
  end

  // Held copy of the check result
  always_ff @(posedge clk) begin
    if (rst) crc_ok_q <= 1'b0;
    else     crc_ok_q <= crc_ok;
  end
`else
  // Without checking, the parity bit carries no information for this block
  logic parity_unused;
  assign parity_unused = payload[0];
  assign crc_ok        = 1'b1;
`endif

endmodule

// File: tb/tb_mtm_alu_resp_receiver.sv
// Randomized scoreboard bench for the ALU response receiver.
// Latency: expects pulses one cycle after the stop bit, timeout on the 65th idle cycle.
// Backpressure: none.
module tb_mtm_alu_resp_receiver;

  localparam int TIMEOUT = 64;
`ifdef MTM_ALU_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        valid;
  logic [31:0] result;
  logic [3:0]  flags;
  logic [5:0]  err_flags;
  logic        is_error;
  logic        crc_ok;
  logic        frame_error;

  mtm_alu_resp_receiver #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .valid       (valid),
    .result      (result),
    .flags       (flags),
    .err_flags   (err_flags),
    .is_error    (is_error),
    .crc_ok      (crc_ok),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        fe;
    bit [31:0] result;
    bit [3:0]  flags;
    bit [5:0]  err;
    bit        is_err;
    bit        crc_ok;
  } ev_t;

  ev_t      exp_q[$];
  ev_t      mon_e;
  bit [7:0] m_bytes[$];
  bit [31:0] h_result;
  bit [3:0]  h_flags;
  bit [5:0]  h_err;
  bit        h_is_err;
  bit        h_crc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int last_fe_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference CRC: remainder of (msg * x^3) divided by x^3+x+1, by polynomial long division
  function automatic bit [2:0] ref_crc(bit [31:0] r, bit [3:0] f);
    bit [39:0] m;
    m = {r, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--) if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
    return m[2:0];
  endfunction

  function automatic ev_t held_ev(bit fe);
    ev_t e;
    e.fe = fe; e.result = h_result; e.flags = h_flags;
    e.err = h_err; e.is_err = h_is_err; e.crc_ok = h_crc;
    return e;
  endfunction

  task automatic model_reset();
    m_bytes.delete();
    h_result = '0; h_flags = '0; h_err = '0; h_is_err = 1'b0; h_crc = !CRC_EN;
  endtask

  task automatic model_fe();
    m_bytes.delete();
    exp_q.push_back(held_ev(1'b1));
  endtask

  // Frame rules: bytes collect until 4, then a result control closes the frame
  task automatic model_pkt(bit typ, bit [7:0] p, bit stop);
    if (!stop) model_fe();
    else if (!typ) begin
      if (m_bytes.size() < 4) m_bytes.push_back(p);
      else model_fe();
    end else if (!p[7]) begin
      if (m_bytes.size() == 4) begin
        h_result = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        h_flags  = p[6:3];
        h_is_err = 1'b0;
        h_crc    = CRC_EN ? (ref_crc(h_result, h_flags) == p[2:0]) : 1'b1;
        m_bytes.delete();
        exp_q.push_back(held_ev(1'b0));
      end else model_fe();
    end else begin
      if (m_bytes.size() == 0) begin
        h_err    = p[6:1];
        h_is_err = 1'b1;
        h_crc    = CRC_EN ? ($countones(p) % 2 == 0) : 1'b1;
        exp_q.push_back(held_ev(1'b0));
      end else model_fe();
    end
  endtask

  task automatic drive_bit(bit b);
    @(posedge clk);
    #1 sin = b;
  endtask

  task automatic send_pkt(bit typ, bit [7:0] p, bit stop = 1'b1);
    bit [10:0] w;
    w = {1'b0, typ, p, stop};
    model_pkt(typ, p, stop);
    for (int i = 10; i >= 0; i--) drive_bit(w[i]);
    stop_cyc = cyc;
  endtask

  // n high cycles right after a packet; more than TIMEOUT of them aborts an open frame
  task automatic idle(int n);
    if (m_bytes.size() != 0 && n > TIMEOUT) model_fe();
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_result(bit [31:0] r, bit [7:0] ctrl, int gap);
    for (int i = 3; i >= 0; i--) begin
      send_pkt(1'b0, r[i*8 +: 8]);
      idle(gap);
    end
    send_pkt(1'b1, ctrl);
  endtask

  task automatic check_outputs_reset(string tag);
    check({tag, "_valid"},  valid, 0);
    check({tag, "_fe"},     frame_error, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_flags"},  flags, 0);
    check({tag, "_err"},    err_flags, 0);
    check({tag, "_iserr"},  is_error, 0);
    check({tag, "_crcok"},  crc_ok, !CRC_EN);
  endtask

  // Monitor: every pulse pops the next expected event
  initial begin
    forever begin
      @(negedge clk);
      if (valid || frame_error) begin
        if (frame_error) last_fe_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: valid=%0b frame_error=%0b, none expected (cycle %0d)",
                   valid, frame_error, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind", {valid, frame_error}, mon_e.fe ? 2'b01 : 2'b10);
          check("result",   result,    mon_e.result);
          check("flags",    flags,     mon_e.flags);
          check("err_flags", err_flags, mon_e.err);
          check("is_error", is_error,  mon_e.is_err);
          check("crc_ok",   crc_ok,    mon_e.crc_ok);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] r;
    bit [3:0]  f;
    bit [5:0]  e;
    int        kind, gap, n;

    rst = 1'b1;
    sin = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_outputs_reset("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);

    // Known frames
    send_result(32'h0000_0005, 8'h01, 0); idle(2);
    send_result(32'h0000_0005, 8'h02, 1); idle(2);
    send_pkt(1'b1, 8'h93); idle(2);
    send_pkt(1'b1, 8'h92); idle(2);

    // Short frame aborted by a result control, then a clean frame
    for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'h10 + 8'(i));
    send_pkt(1'b1, 8'h01); idle(2);
    r = 32'hDEAD_BEEF; f = 4'hA;
    send_result(r, {1'b0, f, ref_crc(r, f)}, 0); idle(2);

    // Open frame left idle: abort on the 65th idle cycle after the stop bit
    send_pkt(1'b0, 8'h11);
    send_pkt(1'b0, 8'h22);
    idle(70);
    check("timeout_cycle", last_fe_cyc - stop_cyc, 65);

    // 64 idle cycles is still inside the window
    send_pkt(1'b0, 8'h33);
    send_pkt(1'b0, 8'h44);
    idle(64);
    send_pkt(1'b0, 8'h55);
    send_pkt(1'b0, 8'h66);
    send_pkt(1'b1, {1'b0, 4'h3, ref_crc(32'h3344_5566, 4'h3)}); idle(2);

    // Reset in the middle of the third data packet: silent discard
    send_pkt(1'b0, 8'hA1);
    send_pkt(1'b0, 8'hA2);
    drive_bit(1'b0); drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    @(posedge clk);
    #1 rst = 1'b1; sin = 1'b1;
    model_reset();
    @(posedge clk);
    #1 check_outputs_reset("midreset");
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    r = 32'h1234_5678; f = 4'h5;
    send_result(r, {1'b0, f, ref_crc(r, f)}, 0); idle(1);

    // Random traffic
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 5);
      gap  = $urandom_range(0, 2);
      r    = $urandom;
      f    = 4'($urandom_range(0, 15));
      case (kind)
        0: send_result(r, {1'b0, f, ref_crc(r, f)}, gap);
        1: send_result(r, {1'b0, 7'($urandom)}, gap);
        2: begin
          e = 6'($urandom);
          send_pkt(1'b1, {1'b1, e, (^{1'b1, e}) ^ 1'($urandom_range(0, 1))});
        end
        3: begin
          n = $urandom_range(0, 6);
          for (int i = 0; i < n; i++) begin
            send_pkt(1'b0, 8'($urandom));
            idle(gap);
          end
          send_pkt(1'b1, 8'($urandom));
        end
        4: send_pkt(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        default: send_pkt(1'($urandom_range(0, 1)), 8'($urandom));
      endcase
      idle($urandom_range(0, 3));
    end

    idle(10);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
